pc_branch_stack: RTL

//   Parametrised program counter with conditional branches and a hardware

---
 rtl/pc_branch_stack_pkg.sv | 18 +
 rtl/pc_branch_stack_if.sv | 30 +++
 rtl/pc_branch_stack_ret_stack.sv | 44 ++++
 rtl/pc_branch_stack.sv | 112 +++++++++++
 4 files changed

// File: rtl/pc_branch_stack_pkg.sv
// Shared widths and opcode constants for the PC / branch / call-stack block.
package pc_branch_stack_pkg;

  localparam int unsigned PC_W_DEF        = 10;
  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned ADDR_W_DEF      = 8;
  localparam int unsigned STACK_DEPTH_DEF = 4;
  localparam int unsigned SP_W_DEF        = 3;
  localparam int unsigned OP_W            = 4;

  localparam logic [OP_W-1:0] OP_JMP  = 4'b0101;
  localparam logic [OP_W-1:0] OP_BZ   = 4'b1000;
  localparam logic [OP_W-1:0] OP_BNZ  = 4'b1001;
  localparam logic [OP_W-1:0] OP_BN   = 4'b1010;
  localparam logic [OP_W-1:0] OP_CALL = 4'b1011;
  localparam logic [OP_W-1:0] OP_RET  = 4'b1100;

endpackage

// File: rtl/pc_branch_stack_if.sv
// Control/status bundle between the instruction path and the PC block.
interface pc_branch_stack_if
  import pc_branch_stack_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned SP_W   = SP_W_DEF
);
  logic              REPC;
  logic              INC;
  logic [OP_W-1:0]   ir_opcode;
  logic [DATA_W-1:0] R_val;
  logic [ADDR_W-1:0] ir_operand_addr;
  logic [PC_W-1:0]   pc;
  logic [SP_W-1:0]   sp;
  logic              branch_taken;
  logic              stack_ovf;
  logic              stack_unf;

  modport master (
    output REPC, INC, ir_opcode, R_val, ir_operand_addr,
    input  pc, sp, branch_taken, stack_ovf, stack_unf
  );

  modport slave (
    input  REPC, INC, ir_opcode, R_val, ir_operand_addr,
    output pc, sp, branch_taken, stack_ovf, stack_unf
  );
endinterface

// File: rtl/pc_branch_stack_ret_stack.sv
// Return-address LIFO; dout always presents the current top entry.
module ret_stack #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset_pc,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  // Occupancy update; caller guarantees push only when not full, pop only when not empty.
  always_comb begin
    count_d = count_q;
    if (push && !full)       count_d = count_q + CNT_W'(1);
    else if (pop && !empty)  count_d = count_q - CNT_W'(1);
  end

  // Occupancy register, cleared by reset so all entries are discarded.
  always_ff @(posedge clk) begin
    if (!reset_pc) count_q <= '0;
    else           count_q <= count_d;
  end

  // Entry storage is not reset; only occupancy decides validity.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[IDX_W'(count_q)] <= din;
  end

  assign dout  = mem_q[IDX_W'(count_q - CNT_W'(1))];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
endmodule

// File: rtl/pc_branch_stack.sv
// Program counter with conditional branches, call/return stack and sticky fault flags.
module pc_branch_stack
  import pc_branch_stack_pkg::*;
#(
  parameter int unsigned PC_W        = PC_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int unsigned SP_W        = SP_W_DEF
) (
  input  logic               clk,
  input  logic               reset_pc,
  pc_branch_stack_if.slave   bus
);
  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            push, pop;
  logic [PC_W-1:0] pc_inc, target, stk_top;
  logic [SP_W-1:0] stk_count;
  logic            stk_full, stk_empty;

  assign pc_inc = pc_q + PC_W'(1);
  assign target = PC_W'(bus.ir_operand_addr);

  ret_stack #(
    .WIDTH (PC_W),
    .DEPTH (STACK_DEPTH),
    .CNT_W (SP_W)
  ) u_ret_stack (
    .clk      (clk),
    .reset_pc (reset_pc),
    .push     (push),
    .pop      (pop),
    .din      (pc_inc),
    .dout     (stk_top),
    .count    (stk_count),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  // Next-PC selection, stack control and flag update for the current opcode.
  always_comb begin
    pc_d    = pc_q;
    taken_d = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (bus.REPC) begin
      unique case (bus.ir_opcode)
        OP_JMP: begin
          pc_d    = target;
          taken_d = 1'b1;
        end
        OP_BZ, OP_BNZ, OP_BN: begin
          if ((bus.ir_opcode == OP_BZ  && bus.R_val == '0) ||
              (bus.ir_opcode == OP_BNZ && bus.R_val != '0) ||
              (bus.ir_opcode == OP_BN  && bus.R_val[DATA_W-1])) begin
            pc_d    = target;
            taken_d = 1'b1;
          end else if (bus.INC) begin
            pc_d = pc_inc;
          end
        end
        OP_CALL: begin
          if (stk_full) begin
            ovf_d = 1'b1;
          end else begin
            push    = 1'b1;
            pc_d    = target;
            taken_d = 1'b1;
          end
        end
        OP_RET: begin
          if (stk_empty) begin
            unf_d = 1'b1;
          end else begin
            pop     = 1'b1;
            pc_d    = stk_top;
            taken_d = 1'b1;
          end
        end
        default: begin
          if (bus.INC) pc_d = pc_inc;
        end
      endcase
    end
  end

  // PC and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_pc) begin
      pc_q    <= '0;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.sp           = stk_count;
  assign bus.branch_taken = taken_q;
  assign bus.stack_ovf    = ovf_q;
  assign bus.stack_unf    = unf_q;
endmodule
